sobel_stream_filter: RTL and testbench

Parametrised streaming 3x3 Sobel edge detector. It accepts raster-order RGB pixels on a busy/valid stream, converts each pixel to grayscale and buffers two image rows. For every complete 3x3 window it emits one saturated gradient magnitude, replicated onto all three colour channels. It replaces the fixed-size Sobel block between the pixel source and the result sink, and adds generic image size, per-channel width, back-pressure stalling and frame wrap.

---
 rtl/sobel_stream_filter_if.sv | 17 +
 rtl/sobel_stream_filter.sv | 129 ++++++++++++
 tb/tb_sobel_stream_filter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_filter_if.sv
// Pixel stream bundle shared by the input (RGB) and output (result) sides of
// sobel_stream_filter.
//   vld  : producer has a pixel on data this cycle
//   data : pixel payload, DW bits
//   busy : consumer cannot take a pixel this cycle
// A transfer happens on a rising edge with vld=1 and busy=0.
// master = producer side, slave = consumer side.
interface sobel_stream_filter_if #(
  parameter int DW = 24
) ();
  logic          vld;
  logic [DW-1:0] data;
  logic          busy;

  modport master (output vld, output data, input busy);
  modport slave  (input vld, input data, output busy);
endinterface

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector.
// Takes raster-order RGB pixels, converts each to grayscale, keeps two rows of
// history and emits one saturated |Gx|+|Gy| per complete 3x3 window, copied
// onto all three colour channels. Border pixels produce no output, so a frame
// yields (IMG_W-2)*(IMG_H-2) results. Frames follow each other with no gap.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   rgb    : input stream (slave), data = {R,G,B}, R in the MSBs
//   result : output stream (master), data = {M,M,M}
// Build option:
//   SOBEL_THRESH_EN : when defined, M is binarised to all-ones when the
//                     saturated magnitude is >= THRESH, else 0.
module sobel_stream_filter #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int CH_W   = 8,
  parameter int THRESH = 90
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sobel_stream_filter_if.slave  rgb,
  sobel_stream_filter_if.master result
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW = CH_W + 4;

  typedef logic [CH_W-1:0] pix_t;

  localparam pix_t PIX_MAX  = '1;
  localparam pix_t THRESH_V = pix_t'(THRESH);
`ifdef SOBEL_THRESH_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  // Whole pipeline freezes while a finished result is waiting on the sink.
  logic en, accept;
  assign en         = !(result.vld && result.busy);
  assign rgb.busy   = !en;
  assign accept     = rgb.vld && en;

  // Grayscale: (R + 2G + B) >> 2, summed at CH_W+2 bits.
  logic [CH_W+1:0] y_sum;
  pix_t            y;
  assign y_sum = {2'b00, rgb.data[3*CH_W-1 -: CH_W]}
               + {1'b0, rgb.data[2*CH_W-1 -: CH_W], 1'b0}
               + {2'b00, rgb.data[CH_W-1:0]};
  assign y     = pix_t'(y_sum >> 2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          window_hit;
  assign window_hit = (row >= RW'(2)) && (col >= CW'(2));

  // Line buffers and window hold pixel data only; they are not reset because
  // anything stale is masked by window_hit.
  pix_t lb0 [IMG_W];  // two rows back
  pix_t lb1 [IMG_W];  // previous row
  pix_t win [3][3];   // [row: 0 = oldest][col: 2 = newest]

  always_ff @(posedge i_clk) begin
    if (!i_rst && accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= y;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb0[col];
      win[1][2] <= lb1[col];
      win[2][2] <= y;
    end
  end

  function automatic logic signed [GW-1:0] ext(input pix_t v);
    return $signed({4'b0000, v});
  endfunction

  logic signed [GW-1:0] gx_c, gy_c, gx, gy;
  assign gx_c = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
  assign gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));

  logic [GW-1:0] abs_x, abs_y, mag_sum;
  pix_t          mag_sat, mag;
  assign abs_x   = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
  assign abs_y   = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
  assign mag_sum = abs_x + abs_y;
  assign mag_sat = (mag_sum > GW'(PIX_MAX)) ? PIX_MAX : pix_t'(mag_sum);
  assign mag     = THRESH_EN ? ((mag_sat >= THRESH_V) ? PIX_MAX : '0) : mag_sat;

  logic s1_vld, s2_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col         <= '0;
      row         <= '0;
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      gx          <= '0;
      gy          <= '0;
      result.vld  <= 1'b0;
      result.data <= '0;
    end else if (en) begin
      if (accept) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      s1_vld <= accept && window_hit;
      s2_vld <= s1_vld;
      if (s1_vld) begin
        gx <= gx_c;
        gy <= gy_c;
      end
      result.vld <= s2_vld;
      if (s2_vld) result.data <= {mag, mag, mag};
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
module tb_sobel_stream_filter;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int TH = 90;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  sobel_stream_filter_if #(.DW(24)) rgb_if ();
  sobel_stream_filter_if #(.DW(24)) res_if ();

  sobel_stream_filter #(.IMG_W(W), .IMG_H(H), .CH_W(8), .THRESH(TH)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .rgb    (rgb_if),
    .result (res_if)
  );

  int nv = 0;
  int nf = 0;
  int cyc = 0;
  int n_out = 0;
  int first_vld = -1;
  int acc_c22 = -1;
  bit stall_mode = 0;
  logic [23:0] pix [W*H];
  int g [H][W];
  int exp_q [$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    nv++;
    if (act !== expv) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: plain 3x3 Sobel on the gray image, centred at (r,c).
  function automatic int model_mag(input int r, input int c);
    int gx, gy, m;
    gx = (g[r-1][c+1] + 2*g[r][c+1] + g[r+1][c+1])
       - (g[r-1][c-1] + 2*g[r][c-1] + g[r+1][c-1]);
    gy = (g[r+1][c-1] + 2*g[r+1][c] + g[r+1][c+1])
       - (g[r-1][c-1] + 2*g[r-1][c] + g[r-1][c+1]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
    m = (m >= TH) ? 255 : 0;
`endif
    return m;
  endfunction

  task automatic set_pix(input int r, input int c, input logic [23:0] v);
    pix[r*W+c] = v;
    g[r][c] = (int'(v[23:16]) + 2*int'(v[15:8]) + int'(v[7:0])) >> 2;
  endtask

  task automatic fill_gray(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) set_pix(r, c, {v[7:0], v[7:0], v[7:0]});
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) set_pix(r, c, 24'($urandom()));
  endtask

  task automatic push_expected();
    for (int r = 1; r < H-1; r++)
      for (int c = 1; c < W-1; c++) exp_q.push_back(model_mag(r, c));
  endtask

  task automatic send_frame(input int n, input bit gaps);
    bit ok;
    int tries;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        rgb_if.vld = 1'b0;
        @(posedge i_clk); #1;
      end
      rgb_if.vld  = 1'b1;
      rgb_if.data = pix[i];
      ok = 0;
      tries = 0;
      while (!ok && tries < 200) begin
        @(negedge i_clk);
        ok = !rgb_if.busy;
        if (ok && i == 2*W+2) acc_c22 = cyc + 1;
        @(posedge i_clk); #1;
        tries++;
      end
      if (!ok) chk("input_accept_timeout", 0, 1);
    end
    rgb_if.vld = 1'b0;
  endtask

  task automatic drain(input string nm, input int base, input int want);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge i_clk);
      t++;
    end
    repeat (5) @(posedge i_clk);
    #1;
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_count"}, n_out - base, want);
    exp_q.delete();
  endtask

  // Sink back-pressure
  initial begin
    res_if.busy = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      res_if.busy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Output checker
  initial begin
    bit prev_stall = 0;
    logic [23:0] prev_data = '0;
    int e;
    logic [7:0] eb;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_stall = 0;
      end else begin
        chk("in_busy_rule", rgb_if.busy, res_if.vld & res_if.busy);
        if (prev_stall) begin
          chk("stall_vld_held", res_if.vld, 1);
          chk("stall_data_held", res_if.data, prev_data);
        end
        if (res_if.vld && first_vld < 0) first_vld = cyc;
        if (res_if.vld && !res_if.busy) begin
          if (exp_q.size() == 0) begin
            chk("spurious_output", res_if.data, -1);
          end else begin
            e  = exp_q.pop_front();
            eb = e[7:0];
            chk("out_data", res_if.data, {eb, eb, eb});
          end
          n_out++;
        end
        prev_stall = res_if.vld && res_if.busy;
        prev_data  = res_if.data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    i_rst       = 1'b1;
    rgb_if.vld  = 1'b0;
    rgb_if.data = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_in_busy", rgb_if.busy, 0);
    chk("rst_out_vld", res_if.vld, 0);
    chk("rst_out_data", res_if.data, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Uniform gray: no edges anywhere
    fill_gray(100);
    chk("model_flat", model_mag(3, 3), 0);
    push_expected();
    base = n_out;
    first_vld = -1;
    send_frame(W*H, 0);
    drain("flat", base, 36);
    chk("latency", first_vld, acc_c22 + 2);

    // Vertical edge between columns 3 and 4
    fill_gray(0);
    for (int r = 0; r < H; r++)
      for (int c = 4; c < W; c++) set_pix(r, c, 24'hFFFFFF);
`ifdef SOBEL_THRESH_EN
    chk("model_step_c3", model_mag(2, 3), 255);
`else
    chk("model_step_c3", model_mag(2, 3), 255);
`endif
    chk("model_step_c4", model_mag(5, 4), 255);
    chk("model_step_c5", model_mag(2, 5), 0);
    chk("model_step_c2", model_mag(4, 2), 0);
    push_expected();
    base = n_out;
    send_frame(W*H, 0);
    drain("step", base, 36);

    // Isolated pixel of gray 10 at (3,3)
    fill_gray(0);
    set_pix(3, 3, {8'd10, 8'd10, 8'd10});
`ifdef SOBEL_THRESH_EN
    chk("model_dot_corner", model_mag(2, 2), 0);
    chk("model_dot_edge", model_mag(2, 3), 0);
`else
    chk("model_dot_corner", model_mag(2, 2), 20);
    chk("model_dot_edge", model_mag(2, 3), 20);
`endif
    chk("model_dot_centre", model_mag(3, 3), 0);
    push_expected();
    base = n_out;
    send_frame(W*H, 0);
    drain("dot", base, 36);

    // Random frame with input bubbles, then the same frame under back-pressure
    fill_random();
    push_expected();
    base = n_out;
    send_frame(W*H, 1);
    drain("rand", base, 36);

    push_expected();
    base = n_out;
    stall_mode = 1;
    send_frame(W*H, 1);
    stall_mode = 0;
    drain("rand_stall", base, 36);

    // Abort a frame after 20 pixels; in-flight results must vanish
    fill_random();
    base = n_out;
    send_frame(20, 0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    chk("abort_outputs", n_out - base, 0);
    fill_random();
    push_expected();
    base = n_out;
    send_frame(W*H, 0);
    drain("after_rst", base, 36);

    // Two back-to-back horizontal-step frames: 0->40 then 0->20
    base = n_out;
    fill_gray(0);
    for (int r = 4; r < H; r++)
      for (int c = 0; c < W; c++) set_pix(r, c, {8'd40, 8'd40, 8'd40});
`ifdef SOBEL_THRESH_EN
    chk("model_h40", model_mag(3, 3), 255);
`else
    chk("model_h40", model_mag(3, 3), 160);
`endif
    push_expected();
    send_frame(W*H, 0);
    fill_gray(0);
    for (int r = 4; r < H; r++)
      for (int c = 0; c < W; c++) set_pix(r, c, {8'd20, 8'd20, 8'd20});
`ifdef SOBEL_THRESH_EN
    chk("model_h20", model_mag(4, 5), 0);
`else
    chk("model_h20", model_mag(4, 5), 80);
`endif
    push_expected();
    send_frame(W*H, 0);
    drain("two_frames", base, 72);

    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
